labi_tick_pipe: RTL and testbench

LABI_TICK_PIPE -- requirements
Module: labi_tick_pipe

---
 rtl/labi_tick_pipe.sv | 99 +++++++++
 tb/tb_labi_tick_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/labi_tick_pipe.sv
// Tick-driven x counter with load, feeding a three-stage valid/ready pipeline
// that emits z = x + 2 and drops samples when stage A cannot accept them.
module labi_tick_pipe #(
    parameter int WIDTH  = 32,
    parameter int PERIOD = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] x_cur,
    output logic [7:0]       drop_cnt,
    output logic [31:0]      cycle
);
    localparam int         NSTG    = 3;
    localparam logic [7:0] TC_LAST = 8'(PERIOD - 1);

    logic [7:0]       tc_reg, tc_next;
    logic [WIDTH-1:0] x_reg, x_next;
    logic [7:0]       drop_reg;
    logic [31:0]      cycle_reg;
    logic             tick, update;

    logic [NSTG-1:0]  valid_reg, valid_next;
    logic [WIDTH-1:0] data_reg  [NSTG];
    logic [WIDTH-1:0] data_next [NSTG];
    logic [WIDTH-1:0] src       [NSTG];
    logic [NSTG-1:0]  take, accept, drain_ok;
    logic             accept_a, accept_b, accept_c;

    assign tick   = en && (tc_reg == TC_LAST);
    assign update = load || tick;

    // Load wins over a coinciding tick: x takes load_val and the tick is lost.
    always_comb begin
        tc_next = tc_reg;
        x_next  = x_reg;
        if (load) begin
            x_next  = load_val;
            tc_next = '0;
        end else if (tick) begin
            x_next  = x_reg + WIDTH'(1);
            tc_next = '0;
        end else if (en) begin
            tc_next = tc_reg + 8'd1;
        end
    end

    // Ready chain built from scalars so there is no loop inside one vector.
    assign accept_c = !valid_reg[2] || out_ready;
    assign accept_b = !valid_reg[1] || accept_c;
    assign accept_a = !valid_reg[0] || accept_b;
    assign accept   = {accept_c, accept_b, accept_a};
    assign drain_ok = {out_ready, accept_c, accept_b};

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign take[gi] = update && accept[gi];
                assign src[gi]  = x_next;
            end else begin : g_body
                assign take[gi] = valid_reg[gi-1] && accept[gi];
                assign src[gi]  = data_reg[gi-1] + WIDTH'(1);
            end
            assign valid_next[gi] = take[gi] | (valid_reg[gi] & ~drain_ok[gi]);
            assign data_next[gi]  = take[gi] ? src[gi] : data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_reg    <= '0;
            x_reg     <= '0;
            valid_reg <= '0;
            drop_reg  <= '0;
            cycle_reg <= '0;
            for (int i = 0; i < NSTG; i++) data_reg[i] <= '0;
        end else begin
            tc_reg    <= tc_next;
            x_reg     <= x_next;
            valid_reg <= valid_next;
            cycle_reg <= cycle_reg + 32'd1;
            if (update && !accept_a && drop_reg != 8'hFF)
                drop_reg <= drop_reg + 8'd1;
            for (int i = 0; i < NSTG; i++) data_reg[i] <= data_next[i];
        end
    end

    assign out_valid = valid_reg[NSTG-1];
    assign out_data  = data_reg[NSTG-1];
    assign x_cur     = x_reg;
    assign drop_cnt  = drop_reg;
    assign cycle     = cycle_reg;
endmodule

// File: tb/tb_labi_tick_pipe.sv
// Directed and randomized bench for labi_tick_pipe, checked against a
// queue-based model of in-flight samples and their pipeline positions.
module tb_labi_tick_pipe;
    localparam int W = 32;
    localparam int P = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [W-1:0] x_cur;
    logic [7:0]   drop_cnt;
    logic [31:0]  cycle;

    labi_tick_pipe #(.WIDTH(W), .PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .x_cur(x_cur), .drop_cnt(drop_cnt), .cycle(cycle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: x/tick arithmetic plus a queue of samples, each with
    // its position (0=A, 1=B, 2=C); the head at position 2 is on the output.
    logic [W-1:0] x_m;
    int           tc_m;
    int           drop_m;
    logic [31:0]  cyc_m;
    logic [W-1:0] q_val[$];
    int           q_pos[$];
    logic [W-1:0] acc_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        x_m = '0; tc_m = 0; drop_m = 0; cyc_m = '0;
        q_val.delete(); q_pos.delete();
    endtask

    task automatic model_edge(input bit e, input bit ld, input logic [W-1:0] lv, input bit rdy);
        bit upd;
        upd = ld || (e && tc_m == P - 1);
        if (ld) begin
            x_m = lv; tc_m = 0;
        end else if (e) begin
            if (tc_m == P - 1) begin tc_m = 0; x_m = x_m + 1; end
            else tc_m++;
        end
        if (q_pos.size() > 0 && q_pos[0] == 2 && rdy) begin
            void'(q_pos.pop_front()); void'(q_val.pop_front());
        end
        for (int i = 0; i < q_pos.size(); i++) begin
            int lim;
            lim = (i == 0) ? 3 : q_pos[i-1];
            if (q_pos[i] + 1 < lim) q_pos[i]++;
        end
        if (upd) begin
            if (q_pos.size() == 0 || q_pos[q_pos.size()-1] > 0) begin
                q_val.push_back(x_m); q_pos.push_back(0);
            end else if (drop_m < 255) begin
                drop_m++;
            end
        end
        cyc_m++;
    endtask

    task automatic check_model();
        bit           exp_v;
        logic [W-1:0] exp_d;
        exp_v = (q_pos.size() > 0) && (q_pos[0] == 2);
        chk("x_cur", x_cur, x_m);
        chk("out_valid", out_valid, exp_v);
        chk("drop_cnt", drop_cnt, drop_m);
        chk("cycle", cycle, cyc_m);
        if (exp_v) begin
            exp_d = q_val[0] + W'(2);
            chk("out_data", out_data, exp_d);
        end
    endtask

    task automatic step(input bit e, input bit ld, input logic [W-1:0] lv, input bit rdy);
        en = e; load = ld; load_val = lv; out_ready = rdy;
        if (out_valid && rdy) begin
            acc_q.push_back(out_data);
            $display("tb: t=%0t accept z=%0h", $time, out_data);
        end
        @(posedge clk);
        model_edge(e, ld, lv, rdy);
        #1;
        check_model();
    endtask

    task automatic do_reset(input string tag);
        en = 1'b0; load = 1'b0; load_val = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_x"}, x_cur, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_cycle"}, cycle, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        do_reset("rst0");

        // Startup timing
        for (int i = 1; i <= 14; i++) begin
            step(1, 0, '0, 1);
            if (i == 7) chk("start_x1", x_cur, 1);
            if (i == 9) begin
                chk("start_valid", out_valid, 1);
                chk("start_z3", out_data, 3);
            end
            if (i == 14) chk("start_x2", x_cur, 2);
        end

        // Load at edge 10
        do_reset("rst_load");
        for (int i = 1; i <= 17; i++) begin
            step(1, i == 10, W'(5), 1);
            if (i == 10) chk("load_x5", x_cur, 5);
            if (i == 12) chk("load_z7", out_data, 7);
            if (i == 16) chk("load_hold5", x_cur, 5);
            if (i == 17) chk("load_x6", x_cur, 6);
        end

        // Load colliding with a tick
        do_reset("rst_coll");
        for (int i = 1; i <= 6; i++) step(1, 0, '0, 1);
        step(1, 1, W'(5), 1);
        chk("coll_x5", x_cur, 5);
        for (int i = 1; i <= 6; i++) step(1, 0, '0, 1);
        chk("coll_hold5", x_cur, 5);
        step(1, 0, '0, 1);
        chk("coll_x6", x_cur, 6);

        // Wrap-around
        step(0, 1, '1, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        chk("wrap_z1", out_data, 1);
        for (int i = 1; i <= 7; i++) step(1, 0, '0, 1);
        chk("wrap_x0", x_cur, 0);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        chk("wrap_z2", out_data, 2);

        // Backpressure from reset
        do_reset("rst_bp");
        for (int i = 1; i <= 40; i++) step(1, 0, '0, 0);
        chk("bp_drop2", drop_cnt, 2);
        chk("bp_x5", x_cur, 5);
        chk("bp_held_z3", out_data, 3);
        acc_q.delete();
        for (int i = 1; i <= 10; i++) step(1, 0, '0, 1);
        for (int i = 0; i < 3; i++)
            chk("bp_order", (acc_q.size() > i) ? {32'd0, acc_q[i]} : 64'hx, 3 + i);

        // Mid-operation reset with B and C occupied
        do_reset("rst_mid0");
        step(0, 1, W'(100), 0);
        step(0, 1, W'(200), 0);
        step(0, 1, W'(300), 0);
        chk("mid_full", out_valid, 1);
        #1;
        do_reset("rst_mid");
        acc_q.delete();
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, '0, 1);
            chk("mid_no_stale", out_valid, 0);
        end
        chk("mid_acc_empty", acc_q.size(), 0);

        // Randomized traffic
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, W'($urandom),
                 $urandom_range(0, 2) != 0);

        // Drop counter saturation
        do_reset("rst_sat");
        for (int i = 0; i < 300; i++) step(0, 1, W'(i), 0);
        chk("sat_255", drop_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
